// File: rtl/dpwm_counter_core.sv
`default_nettype none
// ============================================================================
// Module  : dpwm_counter_core
// Brief   : Coarse period counter/comparator of the DPWM with double-buffered
//           duty, driving the 2-to-4 fine-delay decoder select and enable.
// Revision: 1.0 - initial release
// ============================================================================
module dpwm_counter_core #(
  parameter int N_COARSE = 6,
  parameter int N_FINE   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_COARSE+N_FINE-1:0] duty,
  input  logic                       duty_valid,
  output logic [N_COARSE-1:0]        cnt,
  output logic                       pwm_coarse,
  output logic [N_FINE-1:0]          fine_sel,
  output logic                       fine_en,
  output logic                       period_start,
  output logic                       running
);

  localparam int                  c_DW       = N_COARSE + N_FINE;
  localparam logic [N_COARSE-1:0] c_CNT_MAX  = '1;
  localparam logic [N_COARSE-1:0] c_CNT_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [N_COARSE-1:0] r_cnt;
  logic [c_DW-1:0]     r_active;
  logic [c_DW-1:0]     r_shadow;
  logic                r_pending;
  logic                r_pwm;
  logic [N_FINE-1:0]   r_fine_sel;
  logic                r_fine_en;
  logic                r_period_start;
  logic                r_running;

  state_t              w_state_nxt;
  logic [N_COARSE-1:0] w_cnt_nxt;
  logic [c_DW-1:0]     w_active_nxt;
  logic [c_DW-1:0]     w_shadow_nxt;
  logic                w_pending_nxt;
  logic [N_COARSE-1:0] w_dc_nxt;
  logic [N_FINE-1:0]   w_df_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;

    if (duty_valid) begin
      w_shadow_nxt  = duty;
      w_pending_nxt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = c_CNT_ZERO;
        if (en) begin
          w_state_nxt   = ST_RUN;
          w_active_nxt  = duty_valid ? duty : r_shadow;
          w_pending_nxt = 1'b0;
        end
      end
      default: begin
        if (r_cnt == c_CNT_MAX) begin
          w_cnt_nxt = c_CNT_ZERO;
          // A stop keeps any pending write; RUN entry reloads from the shadow.
          if (!en) begin
            w_state_nxt = ST_IDLE;
          end else if (duty_valid) begin
            w_active_nxt  = duty;
            w_pending_nxt = 1'b0;
          end else if (r_pending) begin
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + N_COARSE'(1);
        end
      end
    endcase
  end

  assign w_dc_nxt = w_active_nxt[c_DW-1:N_FINE];
  assign w_df_nxt = w_active_nxt[N_FINE-1:0];

  // Outputs decode next-state values so they line up with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_active       <= '0;
      r_shadow       <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= 1'b0;
      r_fine_sel     <= '0;
      r_fine_en      <= 1'b0;
      r_period_start <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      if (w_state_nxt == ST_RUN) begin
        r_pwm          <= (w_cnt_nxt < w_dc_nxt);
        r_fine_sel     <= w_df_nxt;
        r_fine_en      <= (w_cnt_nxt == w_dc_nxt) && (w_df_nxt != '0);
        r_period_start <= (w_cnt_nxt == c_CNT_ZERO);
        r_running      <= 1'b1;
      end else begin
        r_pwm          <= 1'b0;
        r_fine_en      <= 1'b0;
        r_period_start <= 1'b0;
        r_running      <= 1'b0;
      end
    end
  end

  assign cnt          = r_cnt;
  assign pwm_coarse   = r_pwm;
  assign fine_sel     = r_fine_sel;
  assign fine_en      = r_fine_en;
  assign period_start = r_period_start;
  assign running      = r_running;

endmodule
`default_nettype wire

// File: tb/tb_dpwm_counter_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpwm_counter_core
// Brief   : Self-checking bench for dpwm_counter_core against a period model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dpwm_counter_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] duty;
  logic       duty_valid;
  logic [5:0] cnt;
  logic       pwm_coarse;
  logic [1:0] fine_sel;
  logic       fine_en;
  logic       period_start;
  logic       running;

  always #5 clk = ~clk;

  dpwm_counter_core #(.N_COARSE(6), .N_FINE(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .cnt          (cnt),
    .pwm_coarse   (pwm_coarse),
    .fine_sel     (fine_sel),
    .fine_en      (fine_en),
    .period_start (period_start),
    .running      (running)
  );

  wire [11:0] got = {cnt, pwm_coarse, fine_sel, fine_en, period_start, running};

  // Reference: position in the period plus the duty that governs it.
  bit m_run;
  int m_cnt, m_act, m_shadow, m_fsel;
  bit m_pend;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [11:0] expv();
    int dc, df;
    dc = m_act / 4;
    df = m_act % 4;
    if (!m_run) return {6'd0, 1'b0, 2'(m_fsel), 3'b000};
    return {6'(m_cnt), 1'(m_cnt < dc), 2'(df), 1'(m_cnt == dc && df != 0),
            1'(m_cnt == 0), 1'b1};
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_act = 0; m_shadow = 0; m_pend = 0; m_fsel = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_cnt = 0;
          m_act = duty_valid ? int'(duty) : m_shadow;
          if (duty_valid) m_shadow = duty;
          m_pend = 0;
        end else if (duty_valid) begin
          m_shadow = duty; m_pend = 1;
        end
      end else if (m_cnt == 63) begin
        m_cnt = 0;
        if (!en) begin
          m_run = 0;
          if (duty_valid) begin m_shadow = duty; m_pend = 1; end
        end else if (duty_valid) begin
          m_act = duty; m_shadow = duty; m_pend = 0;
        end else if (m_pend) begin
          m_act = m_shadow; m_pend = 0;
        end
      end else begin
        m_cnt++;
        if (duty_valid) begin m_shadow = duty; m_pend = 1; end
      end
      if (m_run) m_fsel = m_act % 4;
    end
    #1;
    duty_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; duty = 8'h00; duty_valid = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if (got !== 12'd0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", got, 12'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL reset_idle: got %h want %h", got, expv()); end
    end
  endtask

  task automatic test_duty_zero();
    en = 1'b1; duty = 8'h00; duty_valid = 1'b1;
    for (int i = 0; i < 192; i++) begin
      tick(); n_vec++;
      if (got !== expv() || period_start !== (i % 64 == 0) || pwm_coarse || fine_en) begin
        n_err++; $display("FAIL duty_zero i=%0d: got %h want %h", i, got, expv());
      end
    end
  endtask

  task automatic test_duty_29();
    duty = 8'h29; duty_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL duty_29: got %h want %h", got, expv()); end
      if (m_act == 8'h29) begin
        n_vec++;
        if (pwm_coarse !== (cnt < 10) || fine_en !== (cnt == 10) || fine_sel !== 2'd1) begin
          n_err++; $display("FAIL duty_29_rule cnt=%0d: got %h want pwm=%0d fe=%0d", cnt, got, cnt < 10, cnt == 10);
        end
      end
    end
  endtask

  task automatic test_duty_ff();
    duty = 8'hFF; duty_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL duty_ff: got %h want %h", got, expv()); end
      if (m_act == 8'hFF) begin
        n_vec++;
        if (pwm_coarse !== (cnt <= 62) || fine_en !== (cnt == 63) || fine_sel !== 2'd3) begin
          n_err++; $display("FAIL duty_ff_rule cnt=%0d: got %h", cnt, got);
        end
      end
    end
  endtask

  task automatic test_midperiod_update();
    for (int i = 0; i < 100 && !(m_run && m_cnt == 20); i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL mid_seek: got %h want %h", got, expv()); end
    end
    duty = 8'h10; duty_valid = 1'b1; tick(); n_vec++;
    if (got !== expv()) begin n_err++; $display("FAIL mid_w1: got %h want %h", got, expv()); end
    duty = 8'h80; duty_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL mid_run: got %h want %h", got, expv()); end
      if (m_act == 8'h80) begin
        n_vec++;
        if (fine_en !== 1'b0 || pwm_coarse !== (cnt < 32)) begin
          n_err++; $display("FAIL mid_dc32 cnt=%0d: got %h", cnt, got);
        end
      end
    end
  endtask

  task automatic test_wrap_bypass();
    for (int i = 0; i < 100 && !(m_run && m_cnt == 63); i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL byp_seek: got %h want %h", got, expv()); end
    end
    duty = 8'hC6; duty_valid = 1'b1; tick(); n_vec++;
    if (got !== expv() || cnt !== 6'd0 || fine_sel !== 2'd2 || pwm_coarse !== 1'b1) begin
      n_err++; $display("FAIL wrap_bypass: got %h want %h", got, expv());
    end
    for (int i = 0; i < 64; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL byp_run: got %h want %h", got, expv()); end
    end
  endtask

  task automatic test_stop(input bit cancel);
    for (int i = 0; i < 100 && !(m_run && m_cnt == 30); i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL stop_seek: got %h want %h", got, expv()); end
    end
    en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (cancel && m_run && m_cnt == 40) en = 1'b1;
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL stop c=%0d: got %h want %h", cancel, got, expv()); end
    end
    n_vec++;
    if (running !== cancel) begin
      n_err++; $display("FAIL stop_end c=%0d: running got %b want %b", cancel, running, cancel);
    end
  endtask

  task automatic test_idle_pending();
    duty = 8'h5B; duty_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL idle_wr: got %h want %h", got, expv()); end
    end
    en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL idle_pend: got %h want %h", got, expv()); end
    end
  endtask

  task automatic test_reset_midperiod();
    duty = 8'h80; duty_valid = 1'b1;
    for (int i = 0; i < 200 && !(m_run && m_act == 8'h80 && m_cnt == 25); i++) begin
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL rst_seek: got %h want %h", got, expv()); end
    end
    n_vec++;
    if (pwm_coarse !== 1'b1) begin n_err++; $display("FAIL rst_pre: pwm got %b want 1", pwm_coarse); end
    #2; rst_n = 1'b0; #1;
    model_reset();
    n_vec++;
    if (got !== 12'd0) begin n_err++; $display("FAIL rst_async: got %h want %h", got, 12'd0); end
    tick(); tick();
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick(); n_vec++;
      if (got !== expv() || pwm_coarse !== 1'b0) begin
        n_err++; $display("FAIL rst_restart: got %h want %h", got, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) en = ~en;
      if ($urandom_range(99) < 6) begin duty = 8'($urandom); duty_valid = 1'b1; end
      tick(); n_vec++;
      if (got !== expv()) begin n_err++; $display("FAIL random i=%0d: got %h want %h", i, got, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_duty_zero();
    test_duty_29();
    test_duty_ff();
    test_midperiod_update();
    test_wrap_bypass();
    duty = 8'h29; duty_valid = 1'b1;
    test_stop(1'b0);
    en = 1'b1;
    test_stop(1'b1);
    test_stop(1'b0);
    test_idle_pending();
    test_reset_midperiod();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
